instr_fetch: RTL and testbench

//   Upstream neighbour of the instruction decoder: owns the program counter, fetches 18-bit instructions over a
//   req/ack instruction-memory port and presents one registered instruction at a time on o_instruction[0:17].

---
 rtl/cpu_pkg.sv | 16 +
 rtl/instr_fetch_if.sv | 35 +++
 rtl/fetch_pc.sv | 42 ++++
 rtl/instr_fetch.sv | 130 +++++++++++++
 tb/tb_instr_fetch.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   fetchState_e   : fetch FSM encoding (S_START / S_FETCH / S_VALID), 2 bits
//   FETCH_INSTR_W  : instruction width consumed by the decoder
//   FETCH_ADDR_W   : default PC / instruction-memory address width
package cpu_pkg;

  localparam int FETCH_INSTR_W = 18;
  localparam int FETCH_ADDR_W  = 16;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } fetchState_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request port.
//   imemReq   : fetch request (fetch side -> memory)
//   imemAddr  : fetch address (fetch side -> memory)
//   imemAck   : completion strobe (memory -> fetch side)
//   imemData  : instruction word, meaningful only while imemAck is high
// Handshake: the fetch side raises imemReq and holds imemAddr stable until it
// sees imemAck high on a rising edge. The memory may ack in the same cycle the
// request first appears. One request is outstanding at most; an ack while no
// request is pending carries no meaning and is ignored.
// Modports: master = fetch unit, slave = instruction memory.
interface instr_fetch_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 18
);

  logic               imemReq;
  logic [ADDR_W-1:0]  imemAddr;
  logic               imemAck;
  logic [INSTR_W-1:0] imemData;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemAck,
    input  imemData
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemAck,
    output imemData
  );

endinterface

// File: rtl/fetch_pc.sv
// Program counter register with its next-PC selection.
//   i_clk, i_rst : clock, synchronous active-high reset (PC <- RESET_PC)
//   i_retire     : current instruction retires this cycle
//   i_jTaken     : retiring instruction redirects the PC
//   i_jTarget    : redirect target
//   o_pc         : current PC
// The PC only moves on retire: to the jump target when taken, otherwise +1
// with natural wrap at the top of the address space. Jump inputs are don't-care
// on non-retire cycles.
module fetch_pc #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_retire,
  input  logic              i_jTaken,
  input  logic [ADDR_W-1:0] i_jTarget,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] pcReg;
  logic [ADDR_W-1:0] pcNext;

  always_comb begin
    pcNext = pcReg;
    if (i_retire) begin
      pcNext = i_jTaken ? i_jTarget : pcReg + ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pcReg <= RESET_PC;
    end else begin
      pcReg <= pcNext;
    end
  end

  assign o_pc = pcReg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time over
// the imem port and holds it for the decoder until it retires.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   imem           : instruction-memory request port (master side)
//   o_instruction  : registered instruction, bit 0 first
//   o_instrValid   : o_instruction holds a valid, unretired instruction
//   i_stall        : decoder not ready; instruction held while high
//   i_jTaken       : retiring instruction redirects the PC
//   i_jTarget      : redirect target
//   o_pc           : address of the instruction on o_instruction
//   o_state        : FSM state, for observation
//   o_retireCnt    : retire counter, present only with IFETCH_RETIRE_CNT_EN
// Optional feature: define IFETCH_RETIRE_CNT_EN to add a 16-bit wrapping count
// of retired instructions (sequential and jump retires alike).
// Flow: S_START (one idle cycle after reset) -> S_FETCH (request until ack,
// capture data) -> S_VALID (present until retired) -> S_FETCH ...
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  instr_fetch_if.master      imem,
  output logic [0:INSTR_W-1] o_instruction,
  output logic               o_instrValid,
  input  logic               i_stall,
  input  logic               i_jTaken,
  input  logic [ADDR_W-1:0]  i_jTarget,
  output logic [ADDR_W-1:0]  o_pc,
  output fetchState_e        o_state
`ifdef IFETCH_RETIRE_CNT_EN
  ,
  output logic [15:0]        o_retireCnt
`endif
);

  fetchState_e        state;
  fetchState_e        stateNext;
  logic               fetchReq;
  logic               capture;
  logic               retire;
  logic [0:INSTR_W-1] instrReg;
  logic [ADDR_W-1:0]  pc;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_START;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      S_START: stateNext = S_FETCH;
      S_FETCH: if (imem.imemAck) stateNext = S_VALID;
      S_VALID: if (!i_stall) stateNext = S_FETCH;
      default: stateNext = S_START;
    endcase
  end

  // Output decode. An ack only counts while a request is actually pending,
  // which makes late or stray acks harmless in every other state.
  always_comb begin
    fetchReq     = 1'b0;
    capture      = 1'b0;
    retire       = 1'b0;
    o_instrValid = 1'b0;
    case (state)
      S_FETCH: begin
        fetchReq = 1'b1;
        capture  = imem.imemAck;
      end
      S_VALID: begin
        o_instrValid = 1'b1;
        retire       = !i_stall;
      end
      default: ;
    endcase
  end

  // Instruction register changes only on capture or reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instrReg <= '0;
    end else if (capture) begin
      instrReg <= imem.imemData;
    end
  end

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetchPc (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_retire  (retire),
    .i_jTaken  (i_jTaken),
    .i_jTarget (i_jTarget),
    .o_pc      (pc)
  );

`ifdef IFETCH_RETIRE_CNT_EN
  logic [15:0] retireCnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      retireCnt <= '0;
    end else if (retire) begin
      retireCnt <= retireCnt + 16'd1;
    end
  end

  assign o_retireCnt = retireCnt;
`endif

  // The PC only moves on retire, so it is also the stable fetch address.
  assign imem.imemReq  = fetchReq;
  assign imem.imemAddr = pc;
  assign o_instruction = instrReg;
  assign o_pc          = pc;
  assign o_state       = state;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int          ADDR_W   = 16;
  localparam int          INSTR_W  = 18;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          W        = ADDR_W + INSTR_W;

  // ---------------- clock / reset / DUT ----------------
  logic i_clk;
  logic i_rst;
  logic i_stall;
  logic i_jTaken;
  logic [ADDR_W-1:0] i_jTarget;
  logic [0:INSTR_W-1] o_instruction;
  logic o_instrValid;
  logic [ADDR_W-1:0] o_pc;
  fetchState_e dbgState;
`ifdef IFETCH_RETIRE_CNT_EN
  logic [15:0] o_retireCnt;
`endif

  instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imemBus ();

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .imem          (imemBus.master),
    .o_instruction (o_instruction),
    .o_instrValid  (o_instrValid),
    .i_stall       (i_stall),
    .i_jTaken      (i_jTaken),
    .i_jTarget     (i_jTarget),
    .o_pc          (o_pc),
    .o_state       (dbgState)
`ifdef IFETCH_RETIRE_CNT_EN
    ,
    .o_retireCnt   (o_retireCnt)
`endif
  );

  int cycle = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cycle <= cycle + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [ADDR_W-1:0] modelPc;
  int retires = 0;
  int total = 0;
  int bad = 0;
  int lastValidCycle = 0;

  // memory responder controls: 0 normal, 1 never ack, 2 ack every cycle (junk)
  int respMode = 0;
  int minDelay = 0;
  int maxDelay = 0;
  int waitCnt = 0;
  bit busy = 0;

  function automatic logic [INSTR_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    if (a == 16'h0040) return 18'h2A5A5;
    return ({2'b00, a} * 18'd7) ^ 18'h15A3C;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic noteFail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event missing, expected it (t=%0t)", name, $time);
  endtask

  // ---------------- instruction memory model ----------------
  initial begin
    imemBus.imemAck  = 1'b0;
    imemBus.imemData = '0;
    forever begin
      @(negedge i_clk);
      imemBus.imemAck  = 1'b0;
      imemBus.imemData = 18'($urandom);
      if (respMode == 2) begin
        imemBus.imemAck = 1'b1;
        busy = 0;
      end else if (respMode == 1) begin
        busy = 0;
      end else if (imemBus.imemReq) begin
        if (!busy) begin
          busy = 1;
          waitCnt = $urandom_range(maxDelay, minDelay);
        end
        if (waitCnt == 0) begin
          imemBus.imemAck  = 1'b1;
          imemBus.imemData = memWord(imemBus.imemAddr);
          busy = 0;
        end else begin
          waitCnt--;
        end
      end else begin
        busy = 0;
        // stray acks with garbage data while nothing is requested
        if ($urandom_range(3, 0) == 0) imemBus.imemAck = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prevValid;
    logic [W-1:0] held;
    logic [W-1:0] got;
    prevValid = 1'b0;
    held = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        chk("rst_req", imemBus.imemReq, 0);
        chk("rst_valid", o_instrValid, 0);
        chk("rst_instr", o_instruction, 0);
        chk("rst_pc", o_pc, RESET_PC);
        chk("rst_state", dbgState, S_START);
        prevValid = 1'b0;
      end else begin
        got = {o_pc, o_instruction};
        if (imemBus.imemReq) begin
          chk("req_excl_valid", o_instrValid, 0);
          if (exp_q.size() == 0) noteFail("req_without_expect");
          else chk("req_addr", imemBus.imemAddr, exp_q[0][W-1:INSTR_W]);
        end
        if (o_instrValid && !prevValid) begin
          if (exp_q.size() == 0) noteFail("valid_without_expect");
          else chk("pc_instr", got, exp_q.pop_front());
          held = got;
        end else if (o_instrValid) begin
          chk("hold_pc_instr", got, held);
        end
        prevValid = o_instrValid;
      end
`ifdef IFETCH_RETIRE_CNT_EN
      chk("retire_cnt", o_retireCnt, 16'(retires));
`endif
    end
  end

  // ---------------- driver tasks (all run at negedge + 1) ----------------
  task automatic resetDut(input int modeDuring);
    i_rst = 1'b1;
    i_stall = 1'b1;
    i_jTaken = 1'b0;
    respMode = modeDuring;
    exp_q.delete();
    modelPc = RESET_PC;
    exp_q.push_back({modelPc, memWord(modelPc)});
    retires = 0;
    @(negedge i_clk); #1;
    i_rst = 1'b0;
    respMode = 0;
  endtask

  task automatic waitValid();
    int guard = 0;
    while (!o_instrValid && guard < 100) begin
      @(negedge i_clk); #1;
      guard++;
    end
    if (!o_instrValid) noteFail("wait_valid_timeout");
  endtask

  task automatic waitReq();
    int guard = 0;
    while (!imemBus.imemReq && guard < 100) begin
      @(negedge i_clk); #1;
      guard++;
    end
    if (!imemBus.imemReq) noteFail("wait_req_timeout");
  endtask

  task automatic retireOne(input logic jt, input logic [ADDR_W-1:0] tgt,
                           input int stallCycles, input bit junk);
    waitValid();
    lastValidCycle = cycle;
    for (int s = 0; s < stallCycles; s++) begin
      i_stall = 1'b1;
      i_jTaken = junk ? 1'($urandom_range(1, 0)) : 1'b0;
      i_jTarget = 16'($urandom);
      @(negedge i_clk); #1;
      chk("stall_no_req", imemBus.imemReq, 0);
    end
    i_stall = 1'b0;
    i_jTaken = jt;
    i_jTarget = tgt;
    modelPc = jt ? tgt : modelPc + 16'd1;
    exp_q.push_back({modelPc, memWord(modelPc)});
    retires++;
    @(negedge i_clk); #1;
    i_stall = 1'b1;
    i_jTaken = 1'b0;
    i_jTarget = 16'($urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int prevC;
    int reqCnt;
    i_rst = 1'b1;
    i_stall = 1'b1;
    i_jTaken = 1'b0;
    i_jTarget = '0;
    modelPc = RESET_PC;
    exp_q.push_back({modelPc, memWord(modelPc)});
    @(negedge i_clk); #1;
    i_rst = 1'b0;

    // sequential fetch with same-cycle ack: one instruction every 2 cycles
    minDelay = 0; maxDelay = 0;
    prevC = 0;
    for (int i = 0; i < 5; i++) begin
      retireOne(1'b0, '0, 0, 1'b0);
      if (i > 0) chk("alt_cycle", lastValidCycle - prevC, 2);
      prevC = lastValidCycle;
    end

    // jump from PC=5 to 16'h0100, junk jumps while stalled; then 3-cycle ack
    minDelay = 3; maxDelay = 3;
    waitValid();
    chk("pc_before_jump", o_pc, 16'h0005);
    retireOne(1'b1, 16'h0100, 3, 1'b1);
    reqCnt = 0;
    while (imemBus.imemReq && reqCnt < 20) begin
      chk("delayed_addr", imemBus.imemAddr, 16'h0100);
      reqCnt++;
      @(negedge i_clk); #1;
    end
    chk("req_high_cycles", reqCnt, 4);

    // long stall on a known word
    minDelay = 0; maxDelay = 2;
    retireOne(1'b1, 16'h0040, 0, 1'b0);
    waitValid();
    chk("instr_2a5a5", o_instruction, 18'h2A5A5);
    retireOne(1'b0, '0, 5, 1'b1);

    // PC wrap
    retireOne(1'b1, 16'hFFFF, 1, 1'b0);
    waitValid();
    chk("pc_ffff", o_pc, 16'hFFFF);
    retireOne(1'b0, '0, 0, 1'b0);
    waitReq();
    chk("wrap_addr", imemBus.imemAddr, 16'h0000);

    // random traffic
    minDelay = 0; maxDelay = 3;
    for (int i = 0; i < 150; i++) begin
      retireOne(($urandom_range(3, 0) == 0), 16'($urandom), $urandom_range(3, 0), 1'b1);
    end

    // reset in the middle of a fetch, late ack landing in S_START
    minDelay = 3; maxDelay = 3;
    retireOne(1'b0, '0, 0, 1'b0);
    respMode = 1;
    @(negedge i_clk); #1;
    chk("pre_rst_req", imemBus.imemReq, 1);
    resetDut(2);
    chk("start_state", dbgState, S_START);
    minDelay = 0; maxDelay = 1;
    waitReq();
    chk("post_rst_addr", imemBus.imemAddr, RESET_PC);
    for (int i = 0; i < 6; i++) begin
      retireOne(($urandom_range(3, 0) == 0), 16'($urandom), $urandom_range(2, 0), 1'b1);
    end
    waitValid();
    repeat (3) @(negedge i_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
